// File: rtl/memoria_lector_pkg.sv
// rtl/memoria_lector_pkg.sv - shared encodings, sizes and count saturation for the bank reader
package memoria_lector_pkg;

  localparam int NREG  = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Requests longer than the bank are clamped so no register is read twice per scan
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(NREG)) ? CNT_W'(NREG) : c;
  endfunction

endpackage

// File: rtl/memoria_lector_if.sv
// rtl/memoria_lector_if.sv - (index, data) output stream with valid/ready handshake
interface memoria_lector_if #(
  parameter int N = 16
);
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_idx;
  logic [N-1:0] out_data;

  modport master (output out_valid, output out_idx, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_idx, input  out_data, output out_ready);
endinterface

// File: rtl/memoria_lector_mux16_n.sv
// rtl/memoria_lector_mux16_n.sv - combinational 16:1 word selector for the load path
module mux16_n
  import memoria_lector_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]     d_i [NREG],
  input  logic [IDX_W-1:0] sel_i,
  output logic [N-1:0]     y_o
);

  assign y_o = d_i[sel_i];

endmodule

// File: rtl/memoria_lector.sv
// rtl/memoria_lector.sv - scans a wrap-around range of the register bank onto an output stream
module memoria_lector
  import memoria_lector_pkg::*;
#(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     r1,
  input  logic [N-1:0]     r2,
  input  logic [N-1:0]     r3,
  input  logic [N-1:0]     r4,
  input  logic [N-1:0]     r5,
  input  logic [N-1:0]     r6,
  input  logic [N-1:0]     r7,
  input  logic [N-1:0]     r8,
  input  logic [N-1:0]     r9,
  input  logic [N-1:0]     r10,
  input  logic [N-1:0]     r11,
  input  logic [N-1:0]     r12,
  input  logic [N-1:0]     r13,
  input  logic [N-1:0]     r14,
  input  logic [N-1:0]     r15,
  input  logic [N-1:0]     r16,
  input  logic             start,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  memoria_lector_if.master ob,
  output logic             busy,
  output logic             done
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   rem_q;
  logic               valid_q;
  logic [IDX_W-1:0]   oidx_q;
  logic [N-1:0]       odata_q;
  logic               busy_q;
  logic               done_q;

  logic [N-1:0]       bank [NREG];
  logic [IDX_W-1:0]   sel_d;
  logic [N-1:0]       word_d;

  assign bank = '{r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15, r16};

  // One mux serves both the initial load and every subsequent advance
  assign sel_d = (state_q == ST_IDLE) ? first_idx : idx_q + 4'd1;

  mux16_n #(.N(N)) u_mux (
    .d_i   (bank),
    .sel_i (sel_d),
    .y_o   (word_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      oidx_q  <= '0;
      odata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (count != '0) begin
              idx_q   <= first_idx;
              rem_q   <= sat_count(count);
              oidx_q  <= first_idx;
              odata_q <= word_d;
              valid_q <= 1'b1;
              state_q <= ST_SEND;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end
        ST_SEND: begin
          // Abort beats a coincident handshake: that word is treated as not taken
          if (abort) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (valid_q && ob.out_ready) begin
            if (rem_q == 5'd1) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              idx_q   <= sel_d;
              rem_q   <= rem_q - 5'd1;
              oidx_q  <= sel_d;
              odata_q <= word_d;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ob.out_valid = valid_q;
  assign ob.out_idx   = oidx_q;
  assign ob.out_data  = odata_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_memoria_lector.sv
// tb/tb_memoria_lector.sv - directed vector bench for the bank reader
module tb_memoria_lector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] r [16];
  logic        start;
  logic [3:0]  first_idx;
  logic [4:0]  count;
  logic        abort;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] bank_rst [16] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000,
                                 16'h0025, 16'h0000, 16'h0000, 16'h0404, 16'h0004, 16'h0004,
                                 16'h0004, 16'h8004, 16'hA204, 16'h8004};

  typedef struct {
    logic [3:0]  f;
    logic [4:0]  c;
    int          exp_n;
    logic [15:0] exp_d0;
  } vec_t;

  vec_t vecs [7];

  logic [3:0]  got_idx [$];
  logic [15:0] got_data [$];
  int          n_done;
  int          done_cyc;
  int          timed_out;

  memoria_lector_if #(.N(16)) ob_if ();

  memoria_lector #(.N(16)) dut (
    .clk(clk), .rst(rst),
    .r1(r[0]), .r2(r[1]), .r3(r[2]), .r4(r[3]), .r5(r[4]), .r6(r[5]), .r7(r[6]), .r8(r[7]),
    .r9(r[8]), .r10(r[9]), .r11(r[10]), .r12(r[11]), .r13(r[12]), .r14(r[13]), .r15(r[14]),
    .r16(r[15]),
    .start(start), .first_idx(first_idx), .count(count), .abort(abort),
    .ob(ob_if.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [3:0] f, input logic [4:0] c);
    int cyc;
    got_idx.delete();
    got_data.delete();
    n_done   = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1; first_idx = f; count = c; ob_if.out_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      if (ob_if.out_valid) begin
        got_idx.push_back(ob_if.out_idx);
        got_data.push_back(ob_if.out_data);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      step();
      cyc++;
    end
    timed_out = (cyc >= 40) ? 1 : 0;
  endtask

  initial begin
    logic [3:0] ei;
    for (int i = 0; i < 16; i++) r[i] = bank_rst[i];
    rst = 1'b1; start = 1'b0; first_idx = '0; count = '0; abort = 1'b0;
    ob_if.out_ready = 1'b0;
    vecs[0] = '{4'd0,  5'd16, 16, 16'h0001};
    vecs[1] = '{4'd14, 5'd4,  4,  16'hA204};
    vecs[2] = '{4'd5,  5'd1,  1,  16'h0000};
    vecs[3] = '{4'd0,  5'd0,  0,  16'h0000};
    vecs[4] = '{4'd3,  5'd20, 16, 16'h0001};
    vecs[5] = '{4'd15, 5'd31, 16, 16'h8004};
    vecs[6] = '{4'd9,  5'd3,  3,  16'h0404};
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 32'(ob_if.out_valid), 0);
    chk("rst_idx",   32'(ob_if.out_idx), 0);
    chk("rst_data",  32'(ob_if.out_data), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);

    foreach (vecs[v]) begin
      run_scan(vecs[v].f, vecs[v].c);
      chk($sformatf("v%0d_timeout", v), 32'(timed_out), 0);
      chk($sformatf("v%0d_nwords", v), 32'(got_idx.size()), 32'(vecs[v].exp_n));
      chk($sformatf("v%0d_ndone", v), 32'(n_done), 1);
      chk($sformatf("v%0d_donecyc", v), 32'(done_cyc), 32'(vecs[v].exp_n));
      if (got_data.size() > 0)
        chk($sformatf("v%0d_d0", v), 32'(got_data[0]), 32'(vecs[v].exp_d0));
      foreach (got_idx[k]) begin
        ei = vecs[v].f + 4'(k);
        chk($sformatf("v%0d_idx%0d", v, k), 32'(got_idx[k]), 32'(ei));
        chk($sformatf("v%0d_data%0d", v, k), 32'(got_data[k]), 32'(bank_rst[ei]));
      end
      chk($sformatf("v%0d_busy_end", v), 32'(busy), 0);
    end

    // Backpressure: held word is a snapshot even when r7 changes underneath
    @(negedge clk);
    start = 1'b1; first_idx = 4'd6; count = 5'd2; ob_if.out_ready = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 32'(ob_if.out_valid), 1);
      chk("bp_idx",   32'(ob_if.out_idx), 6);
      chk("bp_data",  32'(ob_if.out_data), 32'h0025);
      if (k == 0) r[6] = 16'h1234;
      step();
    end
    ob_if.out_ready = 1'b1;
    chk("bp_data_rel", 32'(ob_if.out_data), 32'h0025);
    step();
    chk("bp_w1_idx",  32'(ob_if.out_idx), 7);
    chk("bp_w1_data", 32'(ob_if.out_data), 0);
    chk("bp_w1_done", 32'(done), 0);
    step();
    chk("bp_fin_done",  32'(done), 1);
    chk("bp_fin_valid", 32'(ob_if.out_valid), 0);
    chk("bp_fin_busy",  32'(busy), 1);
    step();
    chk("bp_idle_done", 32'(done), 0);
    chk("bp_idle_busy", 32'(busy), 0);
    r[6] = 16'h0025;

    // Abort together with the third handshake
    @(negedge clk);
    start = 1'b1; first_idx = 4'd0; count = 5'd8; ob_if.out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("ab_w0", 32'(ob_if.out_idx), 0);
    step();
    chk("ab_w1", 32'(ob_if.out_idx), 1);
    step();
    chk("ab_w2", 32'(ob_if.out_idx), 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_valid", 32'(ob_if.out_valid), 0);
    chk("ab_busy",  32'(busy), 0);
    chk("ab_done",  32'(done), 0);
    step();
    chk("ab_done2", 32'(done), 0);
    run_scan(4'd2, 5'd3);
    chk("ab_restart_n",    32'(got_idx.size()), 3);
    chk("ab_restart_idx2", 32'(got_idx.size() == 3 ? got_idx[2] : 4'hF), 4);
    chk("ab_restart_done", 32'(n_done), 1);

    // Start ignored mid-scan, then reset during the fifth word
    @(negedge clk);
    start = 1'b1; first_idx = 4'd0; count = 5'd10; ob_if.out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; first_idx = 4'd9; count = 5'd1;
    step();
    start = 1'b0;
    chk("rs_ign_idx",  32'(ob_if.out_idx), 3);
    chk("rs_ign_busy", 32'(busy), 1);
    step();
    chk("rs_w4_idx", 32'(ob_if.out_idx), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_valid", 32'(ob_if.out_valid), 0);
    chk("rs_idx",   32'(ob_if.out_idx), 0);
    chk("rs_data",  32'(ob_if.out_data), 0);
    chk("rs_busy",  32'(busy), 0);
    chk("rs_done",  32'(done), 0);
    step();
    chk("rs_done2",  32'(done), 0);
    chk("rs_valid2", 32'(ob_if.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
